// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and sizing helper for the hazard scoreboard
package hazard_pkg;

    localparam int DEF_REG_ADDR_W = 3;
    localparam int ZERO_REG       = 0;

    // Countdown width large enough to hold the longer of the two latencies (at least 1 bit)
    function automatic int cnt_width(input int load_lat, input int alu_lat);
        int m;
        m = (load_lat > alu_lat) ? load_lat : alu_lat;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode-stage request and stall/status bundle of the hazard scoreboard
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CNT_W      = 16
);

    logic                       dec_valid;
    logic [REG_ADDR_W-1:0]      dec_src_a;
    logic                       dec_src_a_en;
    logic [REG_ADDR_W-1:0]      dec_src_b;
    logic                       dec_src_b_en;
    logic [REG_ADDR_W-1:0]      dec_dst;
    logic                       dec_reg_write;
    logic                       dec_mem_read;
    logic                       flush;
    logic                       stall;
    logic [2**REG_ADDR_W-1:0]   busy;
    logic [CNT_W-1:0]           stall_cnt;

    modport master (
        output dec_valid, dec_src_a, dec_src_a_en, dec_src_b, dec_src_b_en,
               dec_dst, dec_reg_write, dec_mem_read, flush,
        input  stall, busy, stall_cnt
    );

    modport slave (
        input  dec_valid, dec_src_a, dec_src_a_en, dec_src_b, dec_src_b_en,
               dec_dst, dec_reg_write, dec_mem_read, flush,
        output stall, busy, stall_cnt
    );

endinterface

// File: rtl/hazard_reg_timer.sv
// hazard_reg_timer: loadable down-counter tracking how long one register's result stays unforwardable
module hazard_reg_timer #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         busy_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // A fresh load wins over the decrement and is taken unreduced
    always_comb cnt_d = load_i ? val_i : ((cnt_q != '0) ? cnt_q - W'(1) : cnt_q);

    // Countdown register
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;

    assign busy_o = |cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard that stalls decode on unforwardable sources
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int LOAD_LAT   = 1,
    parameter int ALU_LAT    = 0,
    parameter int CNT_W      = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    hazard_scoreboard_if.slave  hz
);

    localparam int            NUM_REGS  = 2**REG_ADDR_W;
    localparam int            TW        = cnt_width(LOAD_LAT, ALU_LAT);
    localparam logic [TW-1:0] LOAD_V    = TW'(LOAD_LAT);
    localparam logic [TW-1:0] ALU_V     = TW'(ALU_LAT);
    localparam logic          TRACK_ALU = (ALU_LAT > 0);

    logic [NUM_REGS-1:0] busy;
    logic                stall;
    logic                issue;
    logic                track;
    logic [TW-1:0]       set_val;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [CNT_W-1:0]    stall_cnt_d;

    // Hazard detection and scoreboard update request, all from registered state plus decode inputs
    always_comb begin
        stall   = hz.dec_valid & ~hz.flush &
                  ((hz.dec_src_a_en & busy[hz.dec_src_a]) | (hz.dec_src_b_en & busy[hz.dec_src_b]));
        issue   = hz.dec_valid & ~stall & ~hz.flush;
        track   = issue & hz.dec_reg_write & (hz.dec_dst != REG_ADDR_W'(ZERO_REG)) &
                  (hz.dec_mem_read | TRACK_ALU);
        set_val = hz.dec_mem_read ? LOAD_V : ALU_V;
    end

    // Register 0 is hardwired and therefore never in flight
    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_timer
        hazard_reg_timer #(.W(TW)) u_timer (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .load_i  (track && (hz.dec_dst == REG_ADDR_W'(r))),
            .val_i   (set_val),
            .busy_o  (busy[r])
        );
    end

    // Saturating count of stalled cycles
    always_comb stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    // Stall statistics register
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;

    assign hz.stall     = stall;
    assign hz.busy      = busy;
    assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector bench for the hazard scoreboard in two configurations
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v = 1'b0, aen = 1'b0, ben = 1'b0, wr = 1'b0, mr = 1'b0, fl = 1'b0;
    logic [2:0] a = '0, b = '0, d = '0;
    int         pass_cnt = 0;
    int         total = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_ADDR_W(3), .CNT_W(16)) ifa ();
    hazard_scoreboard_if #(.REG_ADDR_W(3), .CNT_W(4))  ifb ();

    assign ifa.dec_valid = v;   assign ifa.dec_src_a = a;   assign ifa.dec_src_a_en = aen;
    assign ifa.dec_src_b = b;   assign ifa.dec_src_b_en = ben;  assign ifa.dec_dst = d;
    assign ifa.dec_reg_write = wr;  assign ifa.dec_mem_read = mr;  assign ifa.flush = fl;
    assign ifb.dec_valid = v;   assign ifb.dec_src_a = a;   assign ifb.dec_src_a_en = aen;
    assign ifb.dec_src_b = b;   assign ifb.dec_src_b_en = ben;  assign ifb.dec_dst = d;
    assign ifb.dec_reg_write = wr;  assign ifb.dec_mem_read = mr;  assign ifb.flush = fl;

    hazard_scoreboard #(.REG_ADDR_W(3), .LOAD_LAT(1), .ALU_LAT(0), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .hz(ifa)
    );
    hazard_scoreboard #(.REG_ADDR_W(3), .LOAD_LAT(3), .ALU_LAT(2), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .hz(ifb)
    );

    typedef struct {
        logic       v, aen, ben, wr, mr, fl;
        logic [2:0] a, b, d;
        logic       stall;
        logic [7:0] busy;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic iv, input logic [2:0] ia, input logic iaen,
                                input logic [2:0] ib, input logic iben, input logic [2:0] id,
                                input logic iwr, input logic imr, input logic ifl,
                                input logic es, input logic [7:0] eb);
        vec_t r;
        r.v = iv; r.a = ia; r.aen = iaen; r.b = ib; r.ben = iben; r.d = id;
        r.wr = iwr; r.mr = imr; r.fl = ifl; r.stall = es; r.busy = eb;
        return r;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Apply decode inputs just after a falling edge; outputs are sampled 1ns later
    task automatic drive(input logic iv, input logic [2:0] ia, input logic iaen,
                         input logic [2:0] ib, input logic iben, input logic [2:0] id,
                         input logic iwr, input logic imr, input logic ifl);
        @(negedge clk);
        v = iv; a = ia; aen = iaen; b = ib; ben = iben; d = id; wr = iwr; mr = imr; fl = ifl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // columns: valid, src_a, a_en, src_b, b_en, dst, reg_write, mem_read, flush, exp stall, exp busy
        tbl[0]  = mk(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 1, 0, 0, 8'h00);
        tbl[1]  = mk(1, 3'd3, 1, 3'd0, 0, 3'd1, 1, 0, 0, 1, 8'h08);
        tbl[2]  = mk(1, 3'd3, 1, 3'd0, 0, 3'd1, 1, 0, 0, 0, 8'h00);
        tbl[3]  = mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 1, 1, 0, 0, 8'h00);
        tbl[4]  = mk(1, 3'd0, 1, 3'd0, 1, 3'd0, 0, 0, 0, 0, 8'h00);
        tbl[5]  = mk(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0, 0, 8'h00);
        tbl[6]  = mk(1, 3'd1, 1, 3'd2, 0, 3'd0, 0, 0, 0, 0, 8'h04);
        tbl[7]  = mk(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 1, 0, 0, 8'h00);
        tbl[8]  = mk(1, 3'd0, 0, 3'd0, 0, 3'd6, 1, 1, 0, 0, 8'h40);
        tbl[9]  = mk(1, 3'd0, 0, 3'd6, 1, 3'd0, 0, 0, 0, 1, 8'h40);
        tbl[10] = mk(1, 3'd0, 0, 3'd6, 1, 3'd0, 0, 0, 0, 0, 8'h00);
        tbl[11] = mk(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 0, 0, 8'h00);
        tbl[12] = mk(1, 3'd5, 1, 3'd0, 0, 3'd0, 0, 0, 1, 0, 8'h20);
        tbl[13] = mk(1, 3'd5, 1, 3'd0, 0, 3'd0, 0, 0, 0, 0, 8'h00);
        tbl[14] = mk(1, 3'd7, 1, 3'd0, 0, 3'd7, 1, 1, 0, 0, 8'h00);
        tbl[15] = mk(0, 3'd7, 1, 3'd0, 0, 3'd0, 0, 0, 0, 0, 8'h80);
        tbl[16] = mk(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 0, 8'h00);

        #12;
        chk1("rst_stall_a", ifa.stall, 1'b0);
        chkw("rst_busy_a", 32'(ifa.busy), 32'h0);
        chkw("rst_cnt_a", 32'(ifa.stall_cnt), 32'h0);
        chkw("rst_busy_b", 32'(ifb.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].aen, tbl[i].b, tbl[i].ben, tbl[i].d,
                  tbl[i].wr, tbl[i].mr, tbl[i].fl);
            chk1($sformatf("vec%0d_stall", i), ifa.stall, tbl[i].stall);
            chkw($sformatf("vec%0d_busy", i), 32'(ifa.busy), 32'(tbl[i].busy));
        end
        idle();
        chkw("vec_stall_cnt_a", 32'(ifa.stall_cnt), 32'd2);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chkw("rst2_cnt_a", 32'(ifa.stall_cnt), 32'h0);
        chkw("rst2_cnt_b", 32'(ifb.stall_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load to r5 followed by a src_b reader: one bubble at latency 1, three at latency 3
        drive(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 3'd0, 0, 3'd5, 1, 3'd0, 0, 0, 0);
            chk1($sformatf("lat3_stall_b%0d", i), ifb.stall, i < 3);
            chk1($sformatf("lat3_busy5_b%0d", i), ifb.busy[5], i < 3);
            chk1($sformatf("lat1_stall_a%0d", i), ifa.stall, i == 0);
            chk1($sformatf("lat1_busy5_a%0d", i), ifa.busy[5], i == 0);
        end
        idle();
        chkw("lat3_cnt_b", 32'(ifb.stall_cnt), 32'd3);
        chkw("lat1_cnt_a", 32'(ifa.stall_cnt), 32'd1);

        // ALU write to r4 then a reader: tracked only when ALU_LAT is nonzero
        drive(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'd4, 1, 3'd0, 0, 3'd0, 0, 0, 0);
            chk1($sformatf("alu_stall_b%0d", i), ifb.stall, i < 2);
            chk1($sformatf("alu_stall_a%0d", i), ifa.stall, 1'b0);
        end
        idle();
        chkw("alu_cnt_b", 32'(ifb.stall_cnt), 32'd5);
        chkw("alu_cnt_a", 32'(ifa.stall_cnt), 32'd1);

        // 21 more stall cycles in the 4-bit counter must pin it at all-ones
        for (int k = 0; k < 7; k++) begin
            drive(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 0);
            for (int i = 0; i < 4; i++) drive(1, 3'd0, 0, 3'd5, 1, 3'd0, 0, 0, 0);
        end
        idle();
        chkw("sat_cnt_b", 32'(ifb.stall_cnt), 32'd15);
        chkw("sat_cnt_a", 32'(ifa.stall_cnt), 32'd8);

        // Reset asserted between edges while a dependent is stalled
        drive(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 0);
        drive(1, 3'd0, 0, 3'd5, 1, 3'd0, 0, 0, 0);
        chk1("pre_rst_stall_b", ifb.stall, 1'b1);
        chk1("pre_rst_stall_a", ifa.stall, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk1("arst_stall_b", ifb.stall, 1'b0);
        chkw("arst_busy_b", 32'(ifb.busy), 32'h0);
        chkw("arst_cnt_b", 32'(ifb.stall_cnt), 32'h0);
        chk1("arst_stall_a", ifa.stall, 1'b0);
        chkw("arst_cnt_a", 32'(ifa.stall_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised, clocked successor to the pipeline's combinational load-use hazard check.
- Keeps a per-register countdown scoreboard of in-flight results and stalls IF/ID while the decode-stage instruction reads a register whose value cannot yet be forwarded.
- Supports configurable load latency, an optional no-forwarding mode that also tracks ALU writes, register-0 exclusion, and a saturating stall-cycle counter for performance checks.
- Sits beside the ID stage; its stall output drives PC/IF-ID hold and ID/EX bubble insertion.

Parameters:
- REG_ADDR_W, 3, register-index width; NUM_REGS = 2**REG_ADDR_W.
- LOAD_LAT, 1, cycles after issue during which a load result is unavailable to dependents (1 gives the classic single bubble).
- ALU_LAT, 0, cycles an ALU result is unavailable; 0 means full forwarding and ALU writes are not tracked.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decode stage holds a valid instruction
- dec_src_a  in  REG_ADDR_W  first source register
- dec_src_a_en  in  1  first source is actually read
- dec_src_b  in  REG_ADDR_W  second source (rt, or rs when the decoder selects it)
- dec_src_b_en  in  1  second source is actually read
- dec_dst  in  REG_ADDR_W  destination register
- dec_reg_write  in  1  instruction writes dec_dst
- dec_mem_read  in  1  instruction is a load
- flush  in  1  squash the decode instruction this cycle (branch taken)
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX
- busy  out  NUM_REGS  per-register "result not yet forwardable" bitmap
- stall_cnt  out  CNT_W  cycles with stall=1 since reset, saturating

Behaviour:
- Reset (async, rst_n=0): all countdowns 0, busy=0, stall_cnt=0; stall evaluates to 0.
- Countdown storage: one counter per register, width clog2(max(LOAD_LAT,ALU_LAT)+1); busy[r] = (cnt[r]!=0).
- Register 0: never busy, never set; sources equal to 0 never cause a stall.
- Stall (combinational from registered state and dec_* inputs only): stall = dec_valid & ~flush & ((dec_src_a_en & busy[dec_src_a]) | (dec_src_b_en & busy[dec_src_b])).
- Issue: issue = dec_valid & ~stall & ~flush, evaluated at the clock edge.
- On issue with dec_reg_write & dec_dst!=0:
  - if dec_mem_read, cnt[dec_dst] <= LOAD_LAT;
  - else if ALU_LAT>0, cnt[dec_dst] <= ALU_LAT;
  - else no change.
- Every other nonzero counter decrements by 1 per cycle; a counter at 0 stays at 0.
- Simultaneous set and decrement on the same register: the set wins, with the new value loaded unreduced.
- A stalled or flushed instruction never updates the scoreboard. Already-issued older results keep counting through flush, since they are architecturally committed.
- A source that equals the issuing instruction's own destination stalls only on the older in-flight value; the self-write is not visible until the next cycle.
- Timing with LOAD_LAT=1: load issues at edge t, dependent in decode during t+1 sees busy=1 and stalls one cycle, then issues at t+2 via MEM/WB forwarding.
- Timing with LOAD_LAT=0: loads are never tracked and no stalls occur.
- stall_cnt increments on each clock edge where stall=1, holds at all-ones.
- Reset asserted mid-stall: stall drops immediately, consistent with the combinational path from cleared state.

Decomposition:
- hazard_pkg holds:
  - default REG_ADDR_W;
  - ZERO_REG constant;
  - a function computing counter width from the latencies.
- Sub-module hazard_reg_timer: a single loadable down-counter with a busy flag, instantiated NUM_REGS-1 times by generate (register 0 tied idle).

Test Plan:
- Load-use, defaults: issue load dst=3; next cycle dec src_a=3 en=1 -> stall=1 for exactly 1 cycle, busy[3]=1 then 0, stall_cnt=1.
- Latency 3: LOAD_LAT=3, load dst=5, dependent src_b=5 next cycle -> stall held 3 cycles, dependent issues on cycle 4, stall_cnt=3.
- Register 0 and unused source: load dst=0 then read r0 -> no stall. Load dst=2, then src_b=2 with src_b_en=0 -> no stall.
- No-forwarding mode: ALU_LAT=2, ALU write dst=4 then read src_a=4 -> 2 stall cycles. Same scenario with ALU_LAT=0 -> none.
- Flush and re-set: stalled dependent with flush=1 -> stall=0 and nothing issued, while busy keeps counting. Back-to-back loads to r6 -> counter reloads, dependent stalls LOAD_LAT after the second load.
- Saturation and reset: CNT_W=4 with 20 stall cycles -> stall_cnt=15. Assert rst_n=0 mid-stall -> busy=0, stall=0, stall_cnt=0 asynchronously.
